// File: rtl/switch_debounce_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg : shared constants and types for the switch debounce slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package switch_pkg;
  localparam int NUM_SW           = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT    = 16;

  typedef logic [NUM_SW-1:0] sw_vec_t;
endpackage

`default_nettype wire

// File: rtl/switch_debounce_if.sv
// ---------------------------------------------------------------------------
// switch_debounce_if : raw switch inputs and conditioned A-D levels
// Optional pulses under DEBOUNCE_PULSE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface switch_debounce_if;
  import switch_pkg::*;

  sw_vec_t sw_raw;
  logic    A;
  logic    B;
  logic    C;
  logic    D;
`ifdef DEBOUNCE_PULSE_EN
  sw_vec_t rise;
  sw_vec_t fall;
`endif

  modport master (
    output sw_raw,
    input  A, B, C, D
`ifdef DEBOUNCE_PULSE_EN
    , input rise, fall
`endif
  );

  modport slave (
    input  sw_raw,
    output A, B, C, D
`ifdef DEBOUNCE_PULSE_EN
    , output rise, fall
`endif
  );
endinterface

`default_nettype wire

// File: rtl/switch_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit : one channel - 2-flop synchroniser, stability counter, level
// Edge pulses present only with DEBOUNCE_PULSE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_raw,
  output logic      o_q
`ifdef DEBOUNCE_PULSE_EN
  ,
  output logic      o_rise,
  output logic      o_fall
`endif
);

  logic             r_s1;
  logic             r_s2;
  logic             r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any agreement with the held level restarts the stability window.
      if (r_s2 == r_q) begin
        r_cnt <= '0;
      end else if (w_cnt_last) begin
        r_q   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_q = r_q;

`ifdef DEBOUNCE_PULSE_EN
  logic r_q_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_d <= 1'b0;
    end else begin
      r_q_d <= r_q;
    end
  end

  assign o_rise = r_q & ~r_q_d;
  assign o_fall = ~r_q & r_q_d;
`endif

endmodule

`default_nettype wire

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce : four independent debounce channels driving A-D
// Optional rise/fall pulses with DEBOUNCE_PULSE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module switch_debounce
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  switch_debounce_if.slave  bus
);

  sw_vec_t w_q;
`ifdef DEBOUNCE_PULSE_EN
  sw_vec_t w_rise;
  sw_vec_t w_fall;
`endif

  generate
    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_bit (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_raw  (bus.sw_raw[i]),
        .o_q    (w_q[i])
`ifdef DEBOUNCE_PULSE_EN
        ,
        .o_rise (w_rise[i]),
        .o_fall (w_fall[i])
`endif
      );
    end
  endgenerate

  assign bus.A = w_q[0];
  assign bus.B = w_q[1];
  assign bus.C = w_q[2];
  assign bus.D = w_q[3];

`ifdef DEBOUNCE_PULSE_EN
  assign bus.rise = w_rise;
  assign bus.fall = w_fall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce : directed vector table plus corner sequences, N = 4
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_switch_debounce;

  localparam int N = 4;

  typedef struct {
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[$];

  switch_debounce_if bus ();

  switch_debounce #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {bus.D, bus.C, bus.B, bus.A};
  endfunction

  task automatic add(input logic r, input logic [3:0] sw, input logic [3:0] q,
                     input logic [3:0] ri, input logic [3:0] fa);
    vec_t v;
    v.rst_n = r; v.sw = sw; v.q = q; v.rise = ri; v.fall = fa;
    vecs.push_back(v);
  endtask

  task automatic hold(input int n, input logic r, input logic [3:0] sw, input logic [3:0] q);
    for (int k = 0; k < n; k++) add(r, sw, q, 4'b0000, 4'b0000);
  endtask

  task automatic step(input logic r, input logic [3:0] sw);
    rst_n      = r;
    bus.sw_raw = sw;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input int e, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge %0d got %b want %b", name, e, got, want);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.sw_raw = 4'b0000;

    // reset with all inputs high, then release: outputs appear at edge N+2
    hold(2, 1'b0, 4'b1111, 4'b0000);
    hold(5, 1'b1, 4'b1111, 4'b0000);
    add(1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
    hold(5, 1'b1, 4'b0000, 4'b1111);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    // 3-cycle glitch on bit 1 is rejected
    hold(3, 1'b1, 4'b0010, 4'b0000);
    hold(6, 1'b1, 4'b0000, 4'b0000);
    // bounce on bit 2 then settle high
    hold(1, 1'b1, 4'b0100, 4'b0000);
    hold(1, 1'b1, 4'b0000, 4'b0000);
    hold(1, 1'b1, 4'b0100, 4'b0000);
    hold(1, 1'b1, 4'b0000, 4'b0000);
    hold(5, 1'b1, 4'b0100, 4'b0000);
    add(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    hold(1, 1'b1, 4'b0100, 4'b0100);
    hold(5, 1'b1, 4'b0000, 4'b0100);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    // independent bits A and D
    hold(5, 1'b1, 4'b1001, 4'b0000);
    add(1'b1, 4'b1001, 4'b1001, 4'b1001, 4'b0000);
    hold(5, 1'b1, 4'b1000, 4'b1001);
    add(1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b0001);
    hold(1, 1'b1, 4'b1000, 4'b1000);
    hold(5, 1'b1, 4'b0000, 4'b1000);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    hold(2, 1'b1, 4'b0000, 4'b0000);
    // reset at count 2 on bit 3 discards the pending change
    hold(4, 1'b1, 4'b1000, 4'b0000);
    hold(1, 1'b0, 4'b1000, 4'b0000);
    hold(5, 1'b1, 4'b1000, 4'b0000);
    add(1'b1, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
    hold(1, 1'b1, 4'b1000, 4'b1000);
    hold(5, 1'b1, 4'b0000, 4'b1000);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    hold(3, 1'b1, 4'b0000, 4'b0000);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].sw);
      total++;
      if (outs() !== vecs[i].q) begin
        bad++;
        $display("FAIL vec%0d abcd got %b want %b", i, outs(), vecs[i].q);
      end
`ifdef DEBOUNCE_PULSE_EN
      total++;
      if (bus.rise !== vecs[i].rise) begin
        bad++;
        $display("FAIL vec%0d rise got %b want %b", i, bus.rise, vecs[i].rise);
      end
      total++;
      if (bus.fall !== vecs[i].fall) begin
        bad++;
        $display("FAIL vec%0d fall got %b want %b", i, bus.fall, vecs[i].fall);
      end
      total++;
      if ((bus.rise & bus.fall) !== 4'b0000) begin
        bad++;
        $display("FAIL vec%0d rise_and_fall got %b want 0000", i, bus.rise & bus.fall);
      end
`endif
    end

    // disagreement of exactly N cycles on bit 1 is accepted (edge 6), falls at edge 10
    for (int e = 1; e <= 12; e++) begin
      step(1'b1, (e <= 4) ? 4'b0010 : 4'b0000);
      chk_bit("B_exact_window", e, bus.B, (e >= 6 && e <= 9));
    end
    hold(0, 1'b1, 4'b0000, 4'b0000);

    // bounce at count 3 on bit 0 restarts: A rises at edge 10, not edge 6
    for (int e = 1; e <= 11; e++) begin
      step(1'b1, (e == 4) ? 4'b0000 : 4'b0001);
      chk_bit("A_bounce_restart", e, bus.A, (e >= 10));
    end
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 4'b0000);
      chk_bit("A_release", e, bus.A, (e < 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
